// File: rtl/phase_tdc.sv
// phase_tdc: counter-based phase detector running on the 240 MHz PLL clock.
// Each reference period it reports the delay from the reference rising edge to
// the first signal rising edge (phase_cnt) and the reference period
// (period_cnt), both in clk cycles.
//
// Ports:
//   clk        - 240 MHz PLL clock (only clock in the block)
//   rst_n      - asynchronous active-low reset
//   en         - measurement enable, synchronous to clk
//   ref_in     - asynchronous reference square wave
//   sig_in     - asynchronous measured square wave
//   phase_cnt  - cycles from reference rise to first signal rise
//   period_cnt - cycles between consecutive reference rises
//   meas_valid - one-cycle strobe, phase_cnt/period_cnt updated
//   miss       - one-cycle strobe, period closed with no signal edge
//   timeout    - one-cycle strobe, period counter saturated
//   busy       - high while measuring a period
module phase_tdc #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ref_in,
  input  logic             sig_in,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             miss,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REF = 2'd1,
    MEAS     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Identical pipelines on both inputs keep their relative latency equal.
  logic [SYNC_STAGES-1:0] ref_sync, sig_sync;
  logic                   ref_dly, sig_dly;
  logic                   ref_rise, sig_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sync <= '0;
      sig_sync <= '0;
      ref_dly  <= 1'b0;
      sig_dly  <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
      sig_sync <= {sig_sync[SYNC_STAGES-2:0], sig_in};
      ref_dly  <= ref_sync[SYNC_STAGES-1];
      sig_dly  <= sig_sync[SYNC_STAGES-1];
    end
  end

  assign ref_rise = ref_sync[SYNC_STAGES-1] & ~ref_dly;
  assign sig_rise = sig_sync[SYNC_STAGES-1] & ~sig_dly;

  state_t           state, state_n;
  logic [CNT_W-1:0] per_ctr, per_ctr_n;
  logic [CNT_W-1:0] ph_lat, ph_lat_n;
  logic             got_sig, got_sig_n;
  logic [CNT_W-1:0] phase_n, period_n;
  logic             valid_n, miss_n, timeout_n;

  always_comb begin
    state_n   = state;
    per_ctr_n = per_ctr;
    ph_lat_n  = ph_lat;
    got_sig_n = got_sig;
    phase_n   = phase_cnt;
    period_n  = period_cnt;
    valid_n   = 1'b0;
    miss_n    = 1'b0;
    timeout_n = 1'b0;

    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_n = WAIT_REF;
        end

        WAIT_REF: begin
          if (ref_rise) begin
            state_n   = MEAS;
            per_ctr_n = CNT_ONE;
            got_sig_n = 1'b0;
            if (sig_rise) begin
              ph_lat_n  = '0;
              got_sig_n = 1'b1;
            end
          end
        end

        MEAS: begin
          if (ref_rise) begin
            // Close the current period and start the next one in the same cycle.
            period_n = per_ctr;
            if (got_sig) begin
              phase_n = ph_lat;
              valid_n = 1'b1;
            end else begin
              miss_n = 1'b1;
            end
            per_ctr_n = CNT_ONE;
            got_sig_n = 1'b0;
            // A coincident signal edge belongs to the new period at phase 0.
            if (sig_rise) begin
              ph_lat_n  = '0;
              got_sig_n = 1'b1;
            end
          end else if (per_ctr == CNT_MAX) begin
            timeout_n = 1'b1;
            state_n   = WAIT_REF;
          end else begin
            per_ctr_n = per_ctr + CNT_ONE;
            if (sig_rise && !got_sig) begin
              ph_lat_n  = per_ctr;
              got_sig_n = 1'b1;
            end
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      per_ctr    <= '0;
      ph_lat     <= '0;
      got_sig    <= 1'b0;
      phase_cnt  <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      miss       <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      per_ctr    <= per_ctr_n;
      ph_lat     <= ph_lat_n;
      got_sig    <= got_sig_n;
      phase_cnt  <= phase_n;
      period_cnt <= period_n;
      meas_valid <= valid_n;
      miss       <= miss_n;
      timeout    <= timeout_n;
      // Registered from the next state so busy tracks MEAS without decode logic on the output.
      busy       <= (state_n == MEAS);
    end
  end

endmodule
